// File: rtl/stall_pkg.sv
// Shared constants and types for the scoreboard-based ID-stage stall controller.
package stall_pkg;

  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_ALU_LAT  = 0;
  localparam int unsigned DEF_LOAD_LAT = 1;
  localparam int unsigned DEF_STAT_W   = 16;

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_addr_t;

  // Countdown width able to hold the larger latency; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reg_ready_counter.sv
// One register's ready countdown: decrements to zero, loads max(remaining, latency)
// on a new write, holds while frozen.
module reg_ready_counter
  import stall_pkg::*;
#(
  parameter int unsigned CNT_W = 1
) (
  input  logic             ip_clk,
  input  logic             ip_rst,
  input  logic             ip_freeze,
  input  logic             ip_load,
  input  logic [CNT_W-1:0] ip_lat,
  output logic             op_pending
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_dec;
  logic [CNT_W-1:0] w_next;

  always_comb begin
    w_dec  = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
    // Keeping the longer of outstanding and new latency covers back-to-back writers.
    w_next = (ip_load && (ip_lat > w_dec)) ? ip_lat : w_dec;
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      r_cnt <= '0;
    end else if (!ip_freeze) begin
      r_cnt <= w_next;
    end
  end

  assign op_pending = (r_cnt != '0);

endmodule

// File: rtl/scoreboard_stall_cont.sv
// ID-stage hazard controller: per-register ready scoreboard, issue gating and a
// saturating hazard-stall statistics counter.
module scoreboard_stall_cont
  import stall_pkg::*;
#(
  parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter  int unsigned ALU_LAT  = DEF_ALU_LAT,
  parameter  int unsigned LOAD_LAT = DEF_LOAD_LAT,
  parameter  int unsigned STAT_W   = DEF_STAT_W,
  localparam int unsigned RA_W     = $clog2(NUM_REGS),
  localparam int unsigned CNT_W    = cnt_width(ALU_LAT, LOAD_LAT)
) (
  input  logic                ip_clk,
  input  logic                ip_rst,
  input  logic                ip_valid,
  input  logic [RA_W-1:0]     ip_rs,
  input  logic [RA_W-1:0]     ip_rt,
  input  logic                ip_use_rs,
  input  logic                ip_use_rt,
  input  logic [RA_W-1:0]     ip_dest,
  input  logic                ip_reg_write,
  input  logic                ip_is_load,
  input  logic                ip_freeze,
  input  logic                ip_flush,
  output logic                op_stall,
  output logic                op_issue,
  output logic [NUM_REGS-1:0] op_pending,
  output logic [STAT_W-1:0]   op_stall_count
);

  logic [NUM_REGS-1:0]    w_pending;
  logic [(1<<RA_W)-1:0]   w_pend_ext;
  logic                   w_rs_hit;
  logic                   w_rt_hit;
  logic                   w_stall;
  logic                   w_issue;
  logic                   w_stat_inc;
  logic [CNT_W-1:0]       w_lat;
  logic [STAT_W-1:0]      r_stall_count;

  assign w_pending[0] = 1'b0;
  assign w_lat = ip_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic w_load;
    assign w_load = w_issue & ip_reg_write & (ip_dest == RA_W'(r));
    reg_ready_counter #(.CNT_W(CNT_W)) u_cnt (
      .ip_clk     (ip_clk),
      .ip_rst     (ip_rst),
      .ip_freeze  (ip_freeze),
      .ip_load    (w_load),
      .ip_lat     (w_lat),
      .op_pending (w_pending[r])
    );
  end

  // Zero-extend so any source address can index safely when NUM_REGS is not a power of two.
  always_comb begin
    w_pend_ext = '0;
    w_pend_ext[NUM_REGS-1:0] = w_pending;
  end

  always_comb begin
    w_rs_hit   = ip_use_rs & (ip_rs != '0) & w_pend_ext[ip_rs];
    w_rt_hit   = ip_use_rt & (ip_rt != '0) & w_pend_ext[ip_rt];
    w_stall    = ip_valid & (w_rs_hit | w_rt_hit);
    w_issue    = ip_valid & ~w_stall & ~ip_freeze & ~ip_flush;
    w_stat_inc = w_stall & ~ip_freeze & ~ip_flush;
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      r_stall_count <= '0;
    end else if (w_stat_inc && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + STAT_W'(1);
    end
  end

  assign op_stall       = w_stall;
  assign op_issue       = w_issue;
  assign op_pending     = w_pending;
  assign op_stall_count = r_stall_count;

endmodule

// File: tb/tb_scoreboard_stall_cont.sv
// Directed bench: three configurations share one stimulus bus; each scenario checks
// the instance whose parameters it targets.
module tb_scoreboard_stall_cont;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [4:0] rs, rt, dest;
  logic       use_rs, use_rt, reg_write, is_load, freeze, flush;

  logic        stall_d, issue_d;
  logic [31:0] pend_d;
  logic [15:0] cnt_d;
  logic        stall_n, issue_n;
  logic [31:0] pend_n;
  logic [15:0] cnt_n;
  logic        stall_s, issue_s;
  logic [31:0] pend_s;
  logic [1:0]  cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scoreboard_stall_cont u_def (
    .ip_clk(clk), .ip_rst(rst), .ip_valid(valid), .ip_rs(rs), .ip_rt(rt),
    .ip_use_rs(use_rs), .ip_use_rt(use_rt), .ip_dest(dest), .ip_reg_write(reg_write),
    .ip_is_load(is_load), .ip_freeze(freeze), .ip_flush(flush),
    .op_stall(stall_d), .op_issue(issue_d), .op_pending(pend_d), .op_stall_count(cnt_d)
  );

  scoreboard_stall_cont #(.ALU_LAT(3), .LOAD_LAT(3)) u_nf (
    .ip_clk(clk), .ip_rst(rst), .ip_valid(valid), .ip_rs(rs), .ip_rt(rt),
    .ip_use_rs(use_rs), .ip_use_rt(use_rt), .ip_dest(dest), .ip_reg_write(reg_write),
    .ip_is_load(is_load), .ip_freeze(freeze), .ip_flush(flush),
    .op_stall(stall_n), .op_issue(issue_n), .op_pending(pend_n), .op_stall_count(cnt_n)
  );

  scoreboard_stall_cont #(.STAT_W(2)) u_sat (
    .ip_clk(clk), .ip_rst(rst), .ip_valid(valid), .ip_rs(rs), .ip_rt(rt),
    .ip_use_rs(use_rs), .ip_use_rt(use_rt), .ip_dest(dest), .ip_reg_write(reg_write),
    .ip_is_load(is_load), .ip_freeze(freeze), .ip_flush(flush),
    .op_stall(stall_s), .op_issue(issue_s), .op_pending(pend_s), .op_stall_count(cnt_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ID-stage instruction and let combinational outputs settle.
  task automatic drive(input logic v, input int s, input logic us, input int t,
                       input logic ut, input int d, input logic wr, input logic ld,
                       input logic fz, input logic fl);
    valid = v; rs = 5'(s); use_rs = us; rt = 5'(t); use_rt = ut;
    dest = 5'(d); reg_write = wr; is_load = ld; freeze = fz; flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    checks++; if (pend_d !== 32'h0) begin errors++; $display("FAIL reset_pend got=%h exp=0", pend_d); end
    checks++; if (cnt_d !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt_d); end
    checks++; if (stall_d !== 1'b0 || issue_d !== 1'b0) begin errors++; $display("FAIL reset_stall_issue got=%b%b exp=00", stall_d, issue_d); end
    checks++; if (pend_n !== 32'h0 || pend_s !== 32'h0) begin errors++; $display("FAIL reset_pend_cfg got=%h/%h exp=0", pend_n, pend_s); end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 1, 2, 0, 2, 1, 1, 0, 0);      // lw r2,0(r0)
    checks++; if (issue_d !== 1'b1 || stall_d !== 1'b0) begin errors++; $display("FAIL lu_lw_issue got=%b%b exp=01", stall_d, issue_d); end
    tick();
    checks++; if (pend_d[2] !== 1'b1) begin errors++; $display("FAIL lu_pend2 got=%b exp=1", pend_d[2]); end
    drive(1, 2, 1, 5, 1, 4, 1, 0, 0, 0);      // add r4,r2,r5
    checks++; if (stall_d !== 1'b1 || issue_d !== 1'b0) begin errors++; $display("FAIL lu_stall got=%b%b exp=10", stall_d, issue_d); end
    tick();
    checks++; if (stall_d !== 1'b0 || issue_d !== 1'b1) begin errors++; $display("FAIL lu_issue got=%b%b exp=01", stall_d, issue_d); end
    checks++; if (cnt_d !== 16'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", cnt_d); end
    tick();
    idle();
    checks++; if (cnt_d !== 16'd1 || pend_d !== 32'h0) begin errors++; $display("FAIL lu_after got=%0d/%h exp=1/0", cnt_d, pend_d); end
  endtask

  task automatic test_alu_chain();
    do_reset();
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0, 0);      // add r1,r2,r3
    checks++; if (issue_d !== 1'b1) begin errors++; $display("FAIL alu_add_issue got=%b exp=1", issue_d); end
    tick();
    checks++; if (pend_d[1] !== 1'b0) begin errors++; $display("FAIL alu_pend1 got=%b exp=0", pend_d[1]); end
    drive(1, 1, 1, 7, 1, 6, 1, 0, 0, 0);      // sub r6,r1,r7
    checks++; if (stall_d !== 1'b0 || issue_d !== 1'b1) begin errors++; $display("FAIL alu_sub got=%b%b exp=01", stall_d, issue_d); end
    tick();
    idle();
    checks++; if (pend_d !== 32'h0) begin errors++; $display("FAIL alu_pend_all got=%h exp=0", pend_d); end
  endtask

  task automatic test_no_forward();
    do_reset();
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0, 0);      // add r1,r2,r3
    checks++; if (issue_n !== 1'b1) begin errors++; $display("FAIL nf_add_issue got=%b exp=1", issue_n); end
    tick();
    drive(1, 1, 1, 7, 1, 6, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (stall_n !== 1'b1 || issue_n !== 1'b0) begin errors++; $display("FAIL nf_stall%0d got=%b%b exp=10", i, stall_n, issue_n); end
      tick();
    end
    checks++; if (stall_n !== 1'b0 || issue_n !== 1'b1) begin errors++; $display("FAIL nf_issue got=%b%b exp=01", stall_n, issue_n); end
    checks++; if (cnt_n !== 16'd3) begin errors++; $display("FAIL nf_count got=%0d exp=3", cnt_n); end
    tick();
    idle();
  endtask

  task automatic test_freeze();
    do_reset();
    drive(1, 0, 1, 2, 0, 2, 1, 1, 0, 0);      // lw r2
    tick();
    drive(1, 2, 1, 5, 1, 4, 1, 0, 1, 0);      // dependent held under freeze
    for (int i = 0; i < 5; i++) begin
      checks++; if (stall_d !== 1'b1 || issue_d !== 1'b0) begin errors++; $display("FAIL frz_out%0d got=%b%b exp=10", i, stall_d, issue_d); end
      tick();
      checks++; if (pend_d[2] !== 1'b1 || cnt_d !== 16'd0) begin errors++; $display("FAIL frz_hold%0d got=%b/%0d exp=1/0", i, pend_d[2], cnt_d); end
    end
    drive(1, 2, 1, 5, 1, 4, 1, 0, 0, 0);
    checks++; if (stall_d !== 1'b1 || issue_d !== 1'b0) begin errors++; $display("FAIL frz_unfrz_stall got=%b%b exp=10", stall_d, issue_d); end
    tick();
    checks++; if (stall_d !== 1'b0 || issue_d !== 1'b1 || cnt_d !== 16'd1) begin errors++; $display("FAIL frz_issue got=%b%b/%0d exp=01/1", stall_d, issue_d, cnt_d); end
    tick();
    idle();
  endtask

  task automatic test_reg0_flush();
    do_reset();
    drive(1, 0, 1, 0, 0, 0, 1, 1, 0, 0);      // lw r0
    tick();
    checks++; if (pend_d !== 32'h0) begin errors++; $display("FAIL r0_pend got=%h exp=0", pend_d); end
    drive(1, 0, 1, 0, 1, 8, 1, 0, 0, 0);      // reader of r0
    checks++; if (stall_d !== 1'b0 || issue_d !== 1'b1) begin errors++; $display("FAIL r0_reader got=%b%b exp=01", stall_d, issue_d); end
    tick();
    drive(1, 0, 1, 3, 0, 3, 1, 1, 0, 1);      // lw r3 flushed
    checks++; if (issue_d !== 1'b0) begin errors++; $display("FAIL fl_issue got=%b exp=0", issue_d); end
    tick();
    checks++; if (pend_d[3] !== 1'b0) begin errors++; $display("FAIL fl_pend3 got=%b exp=0", pend_d[3]); end
    drive(1, 0, 1, 2, 0, 2, 1, 1, 0, 0);      // lw r2
    tick();
    drive(1, 2, 1, 5, 1, 4, 1, 0, 0, 1);      // flushed dependent: stalls, not counted
    checks++; if (stall_d !== 1'b1 || issue_d !== 1'b0) begin errors++; $display("FAIL fl_dep got=%b%b exp=10", stall_d, issue_d); end
    tick();
    checks++; if (cnt_d !== 16'd0 || pend_d[2] !== 1'b0) begin errors++; $display("FAIL fl_decr got=%0d/%b exp=0/0", cnt_d, pend_d[2]); end
    idle();
  endtask

  task automatic test_saturation();
    int exp_c;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 1, 2, 0, 2, 1, 1, 0, 0);
      tick();
      drive(1, 2, 1, 5, 1, 4, 1, 0, 0, 0);
      tick();
      tick();
      exp_c = (i > 3) ? 3 : i;
      checks++; if (cnt_s !== 2'(exp_c)) begin errors++; $display("FAIL sat_count%0d got=%0d exp=%0d", i, cnt_s, exp_c); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 0, 1, 9, 0, 9, 1, 1, 0, 0);      // lw r9, latency 3
    tick();
    drive(1, 9, 1, 0, 0, 10, 1, 0, 0, 0);
    tick();
    checks++; if (pend_n[9] !== 1'b1 || cnt_n !== 16'd1) begin errors++; $display("FAIL rm_before got=%b/%0d exp=1/1", pend_n[9], cnt_n); end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (pend_n !== 32'h0 || cnt_n !== 16'd0) begin errors++; $display("FAIL rm_after got=%h/%0d exp=0/0", pend_n, cnt_n); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_chain();
    test_no_forward();
    test_freeze();
    test_reg0_flush();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scoreboard_stall_cont.md
# scoreboard_stall_cont

Parametrised, stateful successor to the MIPS pipeline stall controller. It replaces per-stage destination comparisons with a per-register ready-countdown scoreboard, which gives it three things the stage-compare scheme lacks:
- configurable ALU and load result latencies, covering both forwarding and non-forwarding pipelines;
- a global freeze for multi-cycle memory;
- a saturating hazard-stall statistics counter.

It sits at the ID stage, between decode and the ID/EX pipeline register.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count; register 0 is hardwired zero and never pending.
- ALU_LAT, 0, stall cycles a dependent instruction needs after a non-load writer issues. 0 means full forwarding.
- LOAD_LAT, 1, stall cycles a dependent instruction needs after a load issues. 1 is the classic load-use bubble.
- STAT_W, 16, width of the stall statistics counter.
- Derived (localparam): RA_W = $clog2(NUM_REGS); CNT_W = $clog2(max(ALU_LAT, LOAD_LAT) + 1), minimum 1.

Ports:
- ip_clk  in  1  clock. One clock; every register is on its rising edge.
- ip_rst  in  1  reset, synchronous and active-high.
- ip_valid  in  1  ID holds a real instruction.
- ip_rs / ip_rt  in  RA_W  source register fields.
- ip_use_rs / ip_use_rt  in  1  instruction reads rs / rt.
- ip_dest  in  RA_W  destination register.
- ip_reg_write  in  1  instruction writes ip_dest.
- ip_is_load  in  1  instruction is lw (opcode 6'b100011).
- ip_freeze  in  1  whole pipeline frozen (memory busy).
- ip_flush  in  1  squash the ID instruction (branch taken).
- op_stall  out  1  hazard stall, combinational.
- op_issue  out  1  instruction leaves ID this cycle, combinational.
- op_pending  out  NUM_REGS  per-register "not yet usable" bit; bit 0 is always 0.
- op_stall_count  out  STAT_W  saturating count of hazard-stall cycles.

## Operation
- Each register r in 1..NUM_REGS-1 holds cnt[r] (CNT_W bits). op_pending[r] = (cnt[r] != 0).
- Stall condition, op_stall = ip_valid & ((ip_use_rs & ip_rs != 0 & pending[ip_rs]) | (ip_use_rt & ip_rt != 0 & pending[ip_rt])).
- op_stall does not depend on ip_freeze or ip_flush.
- Issue condition, op_issue = ip_valid & ~op_stall & ~ip_freeze & ~ip_flush.
- Per-cycle update of each cnt[r], when ip_freeze = 0:
  - dec = (cnt[r] == 0) ? 0 : cnt[r] - 1.
  - If op_issue & ip_reg_write & ip_dest == r & r != 0, then cnt[r] <= max(dec, LAT), where LAT = ip_is_load ? LOAD_LAT : ALU_LAT.
  - Otherwise cnt[r] <= dec.
- When ip_freeze = 1, every cnt holds its value.
- A writer to register 0 is ignored.
- A LAT of 0 leaves the register not pending.
- Hazards are checked against the state before the issuing instruction's own write, so "add r3,r3,r4" does not stall on itself.
- WAW case: taking the max keeps the longer of the outstanding and new latencies. This is conservative and correct for an in-order pipeline.
- op_stall_count increments by 1 each cycle where op_stall & ~ip_freeze & ~ip_flush. It saturates at 2^STAT_W - 1 and never wraps.

## Timing
- Reset: every cnt = 0, op_pending = 0, op_stall_count = 0. op_stall and op_issue follow their equations, so they read 0 while ip_valid = 0.
- Reset asserted mid-operation clears all pending state on the next edge. Instructions in flight are not tracked after reset.
- A writer issued in cycle t makes a dependent instruction stall in cycles t+1 .. t+LAT. The dependent issues at t+1+LAT at the earliest, counted in unfrozen cycles.
- Zero-cycle latency from the inputs to op_stall and op_issue. op_pending and op_stall_count are registered.
- Flush and freeze in the same cycle: no issue, counters hold.
- Flush alone: counters decrement and no new entry is written.

## Structure
- Shared package stall_pkg holds:
  - OPC_LW = 6'b100011, OPC_SW, OPC_BEQ, OPC_RTYPE;
  - default latency constants;
  - a typedef for the register-address type.
- One sub-module, reg_ready_counter. It is a single countdown with load-max, freeze and sync reset, and is generated NUM_REGS-1 times.
- The top level holds the hazard muxes, the issue logic and the statistics counter.

## Test plan
- Load-use, default parameters: lw r2 issues at t; add r4,r2,r5 is presented at t+1. Required: op_stall = 1 at t+1 only, op_issue = 1 at t+2, op_stall_count = 1.
- ALU chain with ALU_LAT = 0: add r1 then sub r6,r1,r7 on back-to-back cycles. Required: no stall, op_pending[1] never 1.
- No-forward configuration (ALU_LAT = 3, LOAD_LAT = 3): add r1 issues at t; dependent instruction issues at t+4. Required: op_stall = 1 for 3 cycles.
- Freeze: lw r2 at t, then ip_freeze = 1 during t+1..t+5 with the dependent held at ID. Required: cnt[2] stays at 1, op_stall_count stays at 0; the dependent stalls one unfrozen cycle and then issues.
- Register-0 and flush cases:
  - lw r0 followed by a reader of r0: no stall.
  - lw r3 presented with ip_flush = 1: op_issue = 0, op_pending[3] stays 0.
- Saturation and reset:
  - With STAT_W = 2, force 5 stall cycles: op_stall_count = 3.
  - ip_rst = 1 while op_pending[9] = 1: op_pending = 0 and the count = 0 on the next edge.
